// File: rtl/axil_mem_arbiter.sv
// rtl/axil_mem_arbiter.sv - 2:1 AXI-Lite arbiter sharing one RAM between the imem and dmem ports
module axil_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0: core instruction port
  input  logic [ADDR_W-1:0]     s_imem_awaddr,
  input  logic [2:0]            s_imem_awprot,
  input  logic                  s_imem_awvalid,
  output logic                  s_imem_awready,
  input  logic [DATA_W-1:0]     s_imem_wdata,
  input  logic [DATA_W/8-1:0]   s_imem_wstrb,
  input  logic                  s_imem_wvalid,
  output logic                  s_imem_wready,
  output logic [1:0]            s_imem_bresp,
  output logic                  s_imem_bvalid,
  input  logic                  s_imem_bready,
  input  logic [ADDR_W-1:0]     s_imem_araddr,
  input  logic [2:0]            s_imem_arprot,
  input  logic                  s_imem_arvalid,
  output logic                  s_imem_arready,
  output logic [DATA_W-1:0]     s_imem_rdata,
  output logic [1:0]            s_imem_rresp,
  output logic                  s_imem_rvalid,
  input  logic                  s_imem_rready,
  // requester 1: core data port
  input  logic [ADDR_W-1:0]     s_dmem_awaddr,
  input  logic [2:0]            s_dmem_awprot,
  input  logic                  s_dmem_awvalid,
  output logic                  s_dmem_awready,
  input  logic [DATA_W-1:0]     s_dmem_wdata,
  input  logic [DATA_W/8-1:0]   s_dmem_wstrb,
  input  logic                  s_dmem_wvalid,
  output logic                  s_dmem_wready,
  output logic [1:0]            s_dmem_bresp,
  output logic                  s_dmem_bvalid,
  input  logic                  s_dmem_bready,
  input  logic [ADDR_W-1:0]     s_dmem_araddr,
  input  logic [2:0]            s_dmem_arprot,
  input  logic                  s_dmem_arvalid,
  output logic                  s_dmem_arready,
  output logic [DATA_W-1:0]     s_dmem_rdata,
  output logic [1:0]            s_dmem_rresp,
  output logic                  s_dmem_rvalid,
  input  logic                  s_dmem_rready,
  // shared RAM port
  output logic [ADDR_W-1:0]     m_ram_awaddr,
  output logic [2:0]            m_ram_awprot,
  output logic                  m_ram_awvalid,
  input  logic                  m_ram_awready,
  output logic [DATA_W-1:0]     m_ram_wdata,
  output logic [DATA_W/8-1:0]   m_ram_wstrb,
  output logic                  m_ram_wvalid,
  input  logic                  m_ram_wready,
  input  logic [1:0]            m_ram_bresp,
  input  logic                  m_ram_bvalid,
  output logic                  m_ram_bready,
  output logic [ADDR_W-1:0]     m_ram_araddr,
  output logic [2:0]            m_ram_arprot,
  output logic                  m_ram_arvalid,
  input  logic                  m_ram_arready,
  input  logic [DATA_W-1:0]     m_ram_rdata,
  input  logic [1:0]            m_ram_rresp,
  input  logic                  m_ram_rvalid,
  output logic                  m_ram_rready
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Grant encoding everywhere: 0 = imem, 1 = dmem.
  logic [1:0] r_state_q, r_state_d;
  logic       r_gnt_q, r_gnt_d;
  logic       r_last_q, r_last_d;

  logic [1:0] w_state_q, w_state_d;
  logic       w_gnt_q, w_gnt_d;
  logic       w_last_q, w_last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic r_addr_ph, r_data_ph;
  logic w_addr_ph, w_resp_ph;
  logic sel_awvalid, sel_wvalid;
  logic aw_hs, w_hs;

  // On a tie, fixed mode always favours dmem; round-robin favours whoever was not served last.
  function automatic logic arb_pick(input logic req_imem, input logic req_dmem, input logic last_dmem);
    logic pick;
    if (req_imem && req_dmem) begin
      pick = (ARB_MODE == 1) ? 1'b1 : ~last_dmem;
    end else begin
      pick = req_dmem;
    end
    return pick;
  endfunction

  assign r_addr_ph = (r_state_q == R_ADDR);
  assign r_data_ph = (r_state_q == R_DATA);
  assign w_addr_ph = (w_state_q == W_ADDR);
  assign w_resp_ph = (w_state_q == W_RESP);

  // Read address channel: only the granted requester is forwarded, and only in R_ADDR.
  assign m_ram_araddr   = r_gnt_q ? s_dmem_araddr : s_imem_araddr;
  assign m_ram_arprot   = r_gnt_q ? s_dmem_arprot : s_imem_arprot;
  assign m_ram_arvalid  = r_addr_ph;
  assign s_imem_arready = r_addr_ph & ~r_gnt_q & m_ram_arready;
  assign s_dmem_arready = r_addr_ph &  r_gnt_q & m_ram_arready;

  // Read data channel: payload is broadcast, rvalid is qualified by the grant.
  assign m_ram_rready  = r_data_ph & (r_gnt_q ? s_dmem_rready : s_imem_rready);
  assign s_imem_rdata  = m_ram_rdata;
  assign s_dmem_rdata  = m_ram_rdata;
  assign s_imem_rresp  = m_ram_rresp;
  assign s_dmem_rresp  = m_ram_rresp;
  assign s_imem_rvalid = r_data_ph & ~r_gnt_q & m_ram_rvalid;
  assign s_dmem_rvalid = r_data_ph &  r_gnt_q & m_ram_rvalid;

  // Write address/data: AW and W progress independently; a done flag blocks a second beat.
  assign sel_awvalid    = w_gnt_q ? s_dmem_awvalid : s_imem_awvalid;
  assign sel_wvalid     = w_gnt_q ? s_dmem_wvalid  : s_imem_wvalid;
  assign m_ram_awaddr   = w_gnt_q ? s_dmem_awaddr  : s_imem_awaddr;
  assign m_ram_awprot   = w_gnt_q ? s_dmem_awprot  : s_imem_awprot;
  assign m_ram_wdata    = w_gnt_q ? s_dmem_wdata   : s_imem_wdata;
  assign m_ram_wstrb    = w_gnt_q ? s_dmem_wstrb   : s_imem_wstrb;
  assign m_ram_awvalid  = w_addr_ph & sel_awvalid & ~aw_done_q;
  assign m_ram_wvalid   = w_addr_ph & sel_wvalid  & ~w_done_q;
  assign aw_hs          = m_ram_awvalid & m_ram_awready;
  assign w_hs           = m_ram_wvalid  & m_ram_wready;
  assign s_imem_awready = w_addr_ph & ~w_gnt_q & ~aw_done_q & m_ram_awready;
  assign s_dmem_awready = w_addr_ph &  w_gnt_q & ~aw_done_q & m_ram_awready;
  assign s_imem_wready  = w_addr_ph & ~w_gnt_q & ~w_done_q  & m_ram_wready;
  assign s_dmem_wready  = w_addr_ph &  w_gnt_q & ~w_done_q  & m_ram_wready;

  // Write response channel.
  assign m_ram_bready  = w_resp_ph & (w_gnt_q ? s_dmem_bready : s_imem_bready);
  assign s_imem_bresp  = m_ram_bresp;
  assign s_dmem_bresp  = m_ram_bresp;
  assign s_imem_bvalid = w_resp_ph & ~w_gnt_q & m_ram_bvalid;
  assign s_dmem_bvalid = w_resp_ph &  w_gnt_q & m_ram_bvalid;

  // Read FSM next state: grant in IDLE, wait for AR handshake, then for R handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_gnt_d   = r_gnt_q;
    r_last_d  = r_last_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_imem_arvalid || s_dmem_arvalid) begin
          r_gnt_d   = arb_pick(s_imem_arvalid, s_dmem_arvalid, r_last_q);
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_ram_arvalid && m_ram_arready) begin
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (m_ram_rvalid && m_ram_rready) begin
          r_last_d  = r_gnt_q;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state: a flag set this cycle counts toward leaving W_ADDR.
  always_comb begin
    w_state_d = w_state_q;
    w_gnt_d   = w_gnt_q;
    w_last_d  = w_last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_imem_awvalid || s_imem_wvalid || s_dmem_awvalid || s_dmem_wvalid) begin
          w_gnt_d   = arb_pick(s_imem_awvalid | s_imem_wvalid,
                               s_dmem_awvalid | s_dmem_wvalid, w_last_q);
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (m_ram_bvalid && m_ram_bready) begin
          w_last_d  = w_gnt_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM registers; last = imem after reset so dmem wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_gnt_q   <= r_gnt_d;
      r_last_q  <= r_last_d;
    end
  end

  // Write FSM registers, same tie rule as the read side but an independent pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_gnt_q   <= 1'b0;
      w_last_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_gnt_q   <= w_gnt_d;
      w_last_q  <= w_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// tb/tb_axil_mem_arbiter.sv - scoreboard bench for axil_mem_arbiter (round-robin and fixed-priority instances)
module tb_axil_mem_arbiter;

  logic clk, rst;

  // [instance][requester]; instance g uses ARB_MODE = g, requester 0 = imem, 1 = dmem
  logic [31:0] s_awaddr [2][2];
  logic [2:0]  s_awprot [2][2];
  logic        s_awvalid[2][2];
  logic        s_awready[2][2];
  logic [31:0] s_wdata  [2][2];
  logic [3:0]  s_wstrb  [2][2];
  logic        s_wvalid [2][2];
  logic        s_wready [2][2];
  logic [1:0]  s_bresp  [2][2];
  logic        s_bvalid [2][2];
  logic        s_bready [2][2];
  logic [31:0] s_araddr [2][2];
  logic [2:0]  s_arprot [2][2];
  logic        s_arvalid[2][2];
  logic        s_arready[2][2];
  logic [31:0] s_rdata  [2][2];
  logic [1:0]  s_rresp  [2][2];
  logic        s_rvalid [2][2];
  logic        s_rready [2][2];

  logic [31:0] m_awaddr [2];
  logic [2:0]  m_awprot [2];
  logic        m_awvalid[2];
  logic        m_awready[2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic        m_wvalid [2];
  logic        m_wready [2];
  logic [1:0]  m_bresp  [2];
  logic        m_bvalid [2];
  logic        m_bready [2];
  logic [31:0] m_araddr [2];
  logic [2:0]  m_arprot [2];
  logic        m_arvalid[2];
  logic        m_arready[2];
  logic [31:0] m_rdata  [2];
  logic [1:0]  m_rresp  [2];
  logic        m_rvalid [2];
  logic        m_rready [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axil_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(g)) u_dut (
      .clk(clk), .rst(rst),
      .s_imem_awaddr(s_awaddr[g][0]), .s_imem_awprot(s_awprot[g][0]), .s_imem_awvalid(s_awvalid[g][0]),
      .s_imem_awready(s_awready[g][0]), .s_imem_wdata(s_wdata[g][0]), .s_imem_wstrb(s_wstrb[g][0]),
      .s_imem_wvalid(s_wvalid[g][0]), .s_imem_wready(s_wready[g][0]), .s_imem_bresp(s_bresp[g][0]),
      .s_imem_bvalid(s_bvalid[g][0]), .s_imem_bready(s_bready[g][0]), .s_imem_araddr(s_araddr[g][0]),
      .s_imem_arprot(s_arprot[g][0]), .s_imem_arvalid(s_arvalid[g][0]), .s_imem_arready(s_arready[g][0]),
      .s_imem_rdata(s_rdata[g][0]), .s_imem_rresp(s_rresp[g][0]), .s_imem_rvalid(s_rvalid[g][0]),
      .s_imem_rready(s_rready[g][0]),
      .s_dmem_awaddr(s_awaddr[g][1]), .s_dmem_awprot(s_awprot[g][1]), .s_dmem_awvalid(s_awvalid[g][1]),
      .s_dmem_awready(s_awready[g][1]), .s_dmem_wdata(s_wdata[g][1]), .s_dmem_wstrb(s_wstrb[g][1]),
      .s_dmem_wvalid(s_wvalid[g][1]), .s_dmem_wready(s_wready[g][1]), .s_dmem_bresp(s_bresp[g][1]),
      .s_dmem_bvalid(s_bvalid[g][1]), .s_dmem_bready(s_bready[g][1]), .s_dmem_araddr(s_araddr[g][1]),
      .s_dmem_arprot(s_arprot[g][1]), .s_dmem_arvalid(s_arvalid[g][1]), .s_dmem_arready(s_arready[g][1]),
      .s_dmem_rdata(s_rdata[g][1]), .s_dmem_rresp(s_rresp[g][1]), .s_dmem_rvalid(s_rvalid[g][1]),
      .s_dmem_rready(s_rready[g][1]),
      .m_ram_awaddr(m_awaddr[g]), .m_ram_awprot(m_awprot[g]), .m_ram_awvalid(m_awvalid[g]),
      .m_ram_awready(m_awready[g]), .m_ram_wdata(m_wdata[g]), .m_ram_wstrb(m_wstrb[g]),
      .m_ram_wvalid(m_wvalid[g]), .m_ram_wready(m_wready[g]), .m_ram_bresp(m_bresp[g]),
      .m_ram_bvalid(m_bvalid[g]), .m_ram_bready(m_bready[g]), .m_ram_araddr(m_araddr[g]),
      .m_ram_arprot(m_arprot[g]), .m_ram_arvalid(m_arvalid[g]), .m_ram_arready(m_arready[g]),
      .m_ram_rdata(m_rdata[g]), .m_ram_rresp(m_rresp[g]), .m_ram_rvalid(m_rvalid[g]),
      .m_ram_rready(m_rready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model state, one per instance
  logic [31:0] mem     [2][256];
  logic [31:0] shadow  [2][256];
  logic        r_pend  [2];
  logic [31:0] r_addr  [2];
  logic        aw_got  [2];
  logic        w_got   [2];
  logic        b_pend  [2];
  logic [31:0] aw_addr [2];
  logic [31:0] w_data  [2];
  logic [3:0]  w_strb  [2];
  logic        ram_rstall[2];
  int          aw_cnt  [2];
  int          w_cnt   [2];
  bit          overlap [2];
  logic [31:0] ar_log  [2][$];

  logic        rd_wait [2][2];
  logic        wr_wait [2][2];
  int          stray_cnt;

  logic [31:0] rd_exp_q[4][$];
  logic [1:0]  wr_exp_q[4][$];

  int n_checks;
  int n_fail;

  // RAM model combinational handshake outputs
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      m_arready[g] = ~r_pend[g];
      m_rvalid[g]  = r_pend[g] & ~ram_rstall[g];
      m_rdata[g]   = mem[g][r_addr[g][9:2]];
      m_rresp[g]   = 2'b00;
      m_awready[g] = ~aw_got[g] & ~b_pend[g];
      m_wready[g]  = ~w_got[g] & ~b_pend[g];
      m_bvalid[g]  = b_pend[g];
      m_bresp[g]   = 2'b00;
    end
  end

  // RAM model sequential behaviour plus handshake logging
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        r_pend[g]  <= 1'b0;
        r_addr[g]  <= 32'h0;
        aw_got[g]  <= 1'b0;
        w_got[g]   <= 1'b0;
        b_pend[g]  <= 1'b0;
        aw_cnt[g]  <= 0;
        w_cnt[g]   <= 0;
        overlap[g] <= 1'b0;
        ar_log[g].delete();
      end else begin
        if (m_arvalid[g] && m_arready[g]) begin
          r_pend[g] <= 1'b1;
          r_addr[g] <= m_araddr[g];
          ar_log[g].push_back(m_araddr[g]);
        end else if (m_rvalid[g] && m_rready[g]) begin
          r_pend[g] <= 1'b0;
        end
        if (m_awvalid[g] && m_awready[g]) begin
          aw_got[g]  <= 1'b1;
          aw_addr[g] <= m_awaddr[g];
          aw_cnt[g]  <= aw_cnt[g] + 1;
        end
        if (m_wvalid[g] && m_wready[g]) begin
          w_got[g]  <= 1'b1;
          w_data[g] <= m_wdata[g];
          w_strb[g] <= m_wstrb[g];
          w_cnt[g]  <= w_cnt[g] + 1;
        end
        if (aw_got[g] && w_got[g]) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb[g][b]) mem[g][aw_addr[g][9:2]][b*8 +: 8] <= w_data[g][b*8 +: 8];
          end
          b_pend[g] <= 1'b1;
          aw_got[g] <= 1'b0;
          w_got[g]  <= 1'b0;
        end
        if (m_bvalid[g] && m_bready[g]) b_pend[g] <= 1'b0;
        if ((m_arvalid[g] || r_pend[g]) &&
            (m_awvalid[g] || m_wvalid[g] || aw_got[g] || w_got[g] || b_pend[g])) overlap[g] <= 1'b1;
      end
    end
  end

  // Any rvalid/bvalid shown to a requester that is not waiting for one is a routing error
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 2; r++) begin
        if (s_rvalid[g][r] && !rd_wait[g][r]) stray_cnt <= stray_cnt + 1;
        if (s_bvalid[g][r] && !wr_wait[g][r]) stray_cnt <= stray_cnt + 1;
      end
    end
  end

  function automatic logic any_out(input int g);
    logic v;
    v = m_awvalid[g] | m_wvalid[g] | m_arvalid[g] | m_bready[g] | m_rready[g];
    for (int r = 0; r < 2; r++) begin
      v = v | s_awready[g][r] | s_wready[g][r] | s_arready[g][r] | s_bvalid[g][r] | s_rvalid[g][r];
    end
    return v;
  endfunction

  task automatic clear_inputs();
    for (int g = 0; g < 2; g++) begin
      ram_rstall[g] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        s_awaddr[g][r] = '0; s_awprot[g][r] = '0; s_awvalid[g][r] = 1'b0;
        s_wdata[g][r]  = '0; s_wstrb[g][r]  = '0; s_wvalid[g][r]  = 1'b0;
        s_bready[g][r] = 1'b0;
        s_araddr[g][r] = '0; s_arprot[g][r] = '0; s_arvalid[g][r] = 1'b0;
        s_rready[g][r] = 1'b0;
        rd_wait[g][r]  = 1'b0; wr_wait[g][r] = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One read from requester r of instance g; expected data taken from the shadow memory at issue time
  task automatic do_read(input int g, input int r, input logic [31:0] addr);
    logic [31:0] exp_d, got_d;
    logic [1:0]  got_resp;
    bit          got;
    rd_exp_q[g*2+r].push_back(shadow[g][addr[9:2]]);
    s_araddr[g][r]  = addr;
    s_arvalid[g][r] = 1'b1;
    rd_wait[g][r]   = 1'b1;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_arready[g][r]) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL rd_ar_timeout g=%0d r=%0d addr=%h: no arready within 200 cycles", g, r, addr);
    end
    @(posedge clk);
    #1;
    s_arvalid[g][r] = 1'b0;
    s_rready[g][r]  = 1'b1;
    got = 0; got_d = '0; got_resp = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_rvalid[g][r]) begin got = 1; got_d = s_rdata[g][r]; got_resp = s_rresp[g][r]; break; end
    end
    exp_d = rd_exp_q[g*2+r].pop_front();
    n_checks++;
    if (!got || got_d !== exp_d) begin
      n_fail++;
      $display("FAIL rd_data g=%0d r=%0d addr=%h got=%h (seen=%0d) exp=%h", g, r, addr, got_d, got, exp_d);
    end
    n_checks++;
    if (got_resp !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_resp g=%0d r=%0d got=%b exp=00", g, r, got_resp);
    end
    @(posedge clk);
    #1;
    s_rready[g][r] = 1'b0;
    rd_wait[g][r]  = 1'b0;
  endtask

  // One write with independent AW and W start delays (in cycles)
  task automatic do_write(input int g, input int r, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
    logic [1:0] exp_b, got_b;
    bit         got;
    wr_exp_q[g*2+r].push_back(2'b00);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) shadow[g][addr[9:2]][b*8 +: 8] = data[b*8 +: 8];
    end
    wr_wait[g][r] = 1'b1;
    fork
      begin
        bit ok;
        repeat (aw_dly) begin @(posedge clk); #1; end
        s_awaddr[g][r] = addr; s_awvalid[g][r] = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (s_awready[g][r]) begin ok = 1; break; end
        end
        if (!ok) begin
          n_checks++; n_fail++;
          $display("FAIL wr_aw_timeout g=%0d r=%0d addr=%h", g, r, addr);
        end
        @(posedge clk); #1;
        s_awvalid[g][r] = 1'b0;
      end
      begin
        bit ok;
        repeat (w_dly) begin @(posedge clk); #1; end
        s_wdata[g][r] = data; s_wstrb[g][r] = strb; s_wvalid[g][r] = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (s_wready[g][r]) begin ok = 1; break; end
        end
        if (!ok) begin
          n_checks++; n_fail++;
          $display("FAIL wr_w_timeout g=%0d r=%0d addr=%h", g, r, addr);
        end
        @(posedge clk); #1;
        s_wvalid[g][r] = 1'b0;
      end
    join
    s_bready[g][r] = 1'b1;
    got = 0; got_b = 2'bxx;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_bvalid[g][r]) begin got = 1; got_b = s_bresp[g][r]; break; end
    end
    exp_b = wr_exp_q[g*2+r].pop_front();
    n_checks++;
    if (!got || got_b !== exp_b) begin
      n_fail++;
      $display("FAIL wr_bresp g=%0d r=%0d got=%b (seen=%0d) exp=%b", g, r, got_b, got, exp_b);
    end
    @(posedge clk); #1;
    s_bready[g][r] = 1'b0;
    wr_wait[g][r]  = 1'b0;
  endtask

  task automatic check_log(input int g, input logic [31:0] exp_addr[$], input string name);
    n_checks++;
    if (ar_log[g].size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL %s_count g=%0d got=%0d exp=%0d", name, g, ar_log[g].size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        n_checks++;
        if (ar_log[g][i] !== exp_addr[i]) begin
          n_fail++;
          $display("FAIL %s_order g=%0d idx=%0d got=%h exp=%h", name, g, i, ar_log[g][i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic check_stray(input string name);
    n_checks++;
    if (stray_cnt !== 0) begin
      n_fail++;
      $display("FAIL %s_stray got=%0d exp=0", name, stray_cnt);
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (any_out(g) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs g=%0d got=%b exp=0", g, any_out(g));
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (any_out(g) !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_outputs g=%0d got=%b exp=0", g, any_out(g));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    apply_reset();
    do_read(0, 1, 32'h0000_0010);
    check_log(0, '{32'h10}, "single_read_ar");
    check_stray("single_read");
  endtask

  task automatic test_rr_tie();
    apply_reset();
    fork
      do_read(0, 0, 32'h100);
      begin
        do_read(0, 1, 32'h200);
        do_read(0, 1, 32'h204);
      end
    join
    check_log(0, '{32'h200, 32'h100, 32'h204}, "rr_tie");
    check_stray("rr_tie");
  endtask

  task automatic test_write_orders();
    logic [31:0] vals [3] = '{32'h1111_2222, 32'h3333_4444, 32'hA5A5_5A5A};
    int          awd  [3] = '{0, 3, 0};
    int          wd   [3] = '{3, 0, 0};
    for (int i = 0; i < 3; i++) begin
      int aw0, w0;
      apply_reset();
      aw0 = aw_cnt[0]; w0 = w_cnt[0];
      do_write(0, 1, 32'h40, vals[i], 4'hF, awd[i], wd[i]);
      n_checks++;
      if (aw_cnt[0] - aw0 != 1) begin
        n_fail++;
        $display("FAIL write_aw_beats case=%0d got=%0d exp=1", i, aw_cnt[0] - aw0);
      end
      n_checks++;
      if (w_cnt[0] - w0 != 1) begin
        n_fail++;
        $display("FAIL write_w_beats case=%0d got=%0d exp=1", i, w_cnt[0] - w0);
      end
      do_read(0, 1, 32'h40);
    end
    check_stray("write_orders");
  endtask

  task automatic test_concurrent();
    apply_reset();
    fork
      do_read(0, 0, 32'h0);
      do_write(0, 1, 32'h80, 32'h1234_5678, 4'hF, 0, 0);
    join
    n_checks++;
    if (overlap[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL concurrent_overlap got=%b exp=1", overlap[0]);
    end
    do_read(0, 1, 32'h80);
    check_stray("concurrent");
  endtask

  task automatic test_fixed_vs_rr();
    apply_reset();
    fork
      begin for (int i = 0; i < 4; i++) do_read(0, 1, 32'h300 + 32'(i*4)); end
      do_read(0, 0, 32'h4);
      begin for (int i = 0; i < 4; i++) do_read(1, 1, 32'h300 + 32'(i*4)); end
      do_read(1, 0, 32'h4);
    join
    check_log(0, '{32'h300, 32'h4, 32'h304, 32'h308, 32'h30C}, "rr_mode");
    check_log(1, '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h4}, "fixed_mode");
    check_stray("fixed_vs_rr");
  endtask

  task automatic test_reset_mid_read();
    bit got;
    apply_reset();
    ram_rstall[0] = 1'b1;
    s_araddr[0][0] = 32'h8; s_arvalid[0][0] = 1'b1; rd_wait[0][0] = 1'b1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_arready[0][0]) begin got = 1; break; end
    end
    @(posedge clk); #1;
    s_arvalid[0][0] = 1'b0; s_rready[0][0] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (!got || m_rready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_in_rdata got_rready=%b ar_seen=%0d exp=1", m_rready[0], got);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (any_out(0) !== 1'b0 || any_out(1) !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got=%b%b exp=00", any_out(0), any_out(1));
    end
    clear_inputs();
    @(posedge clk); #1 rst = 1'b0;
    do_read(0, 0, 32'h8);
    check_stray("mid_reset");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    stray_cnt = 0;
    rst       = 1'b1;
    clear_inputs();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 256; i++) begin
        mem[g][i]    = 32'h5000_0000 + 32'(i);
        shadow[g][i] = 32'h5000_0000 + 32'(i);
      end
      mem[g][4]    = 32'hDEAD_BEEF;
      shadow[g][4] = 32'hDEAD_BEEF;
    end
    #1;
    test_reset();
    test_single_read();
    test_rr_tie();
    test_write_orders();
    test_concurrent();
    test_fixed_vs_rr();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_mem_arbiter.md
Name: axil_mem_arbiter

Overview:
- 2:1 AXI4-Lite arbiter that lets the core's instruction port and data port share one AXI-Lite RAM.
- Sits between the core wrapper's imem/dmem AXI-Lite buses and a single axil_ram_wrap instance.
- Read and write channels are arbitrated independently. Each channel allows one outstanding transaction.
- Responses are routed back to the requester that was granted.

Parameters:
- ADDR_W, 32, AXI-Lite address width; must match axil_if.
- DATA_W, 32, AXI-Lite data width; STRB width is DATA_W/8.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with dmem always winning.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- s_imem  axil_if slave modport  ADDR_W/DATA_W  requester 0, the core instruction port.
- s_dmem  axil_if slave modport  ADDR_W/DATA_W  requester 1, the core data port.
- m_ram  axil_if master modport  ADDR_W/DATA_W  shared RAM port.

Behaviour:
- Reset (async assert, sync deassert use):
  - Both FSMs go to IDLE.
  - All m_ram valid signals are 0: awvalid, wvalid, arvalid.
  - All m_ram ready signals are 0: bready, rready.
  - All slave-side ready signals are 0: awready, wready, arready.
  - All slave-side valid signals are 0: bvalid, rvalid.
  - Round-robin pointers are set so that dmem wins the first tie.
- Read FSM, states R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: sample both arvalid. With none asserted, stay. With one asserted, grant it. With both asserted, grant per ARB_MODE and round-robin pointer. Register the grant and go to R_ADDR.
  - R_ADDR:
    - Drive m_ram.araddr/arprot from the granted slave and set m_ram.arvalid = 1.
    - The granted slave's arready = m_ram.arready; the other slave's arready = 0.
    - On the arvalid & arready handshake, go to R_DATA.
  - R_DATA:
    - Route m_ram.rdata/rresp/rvalid to the granted slave; m_ram.rready = granted slave's rready.
    - The non-granted slave sees rvalid = 0.
    - On the rvalid & rready handshake: update the pointer to "last = granted" and go to R_IDLE.
- Write FSM, states W_IDLE -> W_ADDR -> W_RESP -> W_IDLE:
  - W_IDLE: a slave requests when awvalid | wvalid is set. Arbitrate the same way as reads, using a separate pointer.
  - W_ADDR:
    - Forward AW and W from the granted slave independently.
    - Track aw_done and w_done flags. m_ram.awvalid = granted awvalid & ~aw_done, and likewise for W.
    - Slave awready/wready mirror m_ram's readies while the matching flag is clear, and are 0 otherwise.
    - The AW and W handshakes may complete in the same cycle or in any order.
    - Go to W_RESP when both flags are set, counting a flag set in the current cycle.
  - W_RESP: route bresp/bvalid to the granted slave and bready back to m_ram. On the handshake, update the pointer, clear the flags, and go to W_IDLE.
- Latency:
  - One added cycle on the address path (IDLE grant cycle).
  - Data and response paths are combinational pass-through.
  - Back-to-back reads cost at least 1 idle cycle each.
- Fairness:
  - Round-robin: on a tie, grant the requester not granted last. No requester waits more than one transaction.
  - Fixed mode: imem can starve while dmem requests continuously; this is accepted behaviour.
- Simultaneous events:
  - A read and a write may be in flight concurrently to m_ram, one from each requester or both from the same one.
  - A new request arriving during a transaction is held; masters keep valid asserted per AXI rules.
- The non-granted slave never sees any ready or valid asserted.
- Reset mid-transaction:
  - All state is abandoned and nothing is replayed.
  - The RAM and masters are reset on the same rst, so no orphan beats remain.

Test Plan:
- Reset, then a single dmem read of 0x0000_0010 (RAM preloaded 0xDEAD_BEEF) -> one m_ram.araddr = 0x10 handshake; s_dmem.rdata = 0xDEADBEEF, rresp = OKAY; s_imem sees no rvalid.
- imem and dmem both assert arvalid in the same cycle (0x100, 0x200) with ARB_MODE=0 -> dmem is granted first and imem second; then both assert again and imem is granted first.
- dmem write 0x0000_0040 = 0xA5A5_5A5A, strb 0xF, with W asserted 3 cycles after AW; repeat with W before AW and with W and AW together -> exactly one AW and one W reach m_ram; bvalid appears only at s_dmem; a later read of 0x40 returns 0xA5A55A5A.
- Concurrent imem read of 0x0 and dmem write of 0x80 -> both complete, with overlapping m_ram read and write channel activity and correct per-requester routing.
- ARB_MODE=1, dmem issuing continuous reads while imem reads 0x4 -> imem is granted only when dmem arvalid is low; with ARB_MODE=0 under the same stimulus, grants alternate 1:1.
- Assert rst while in R_DATA with m_ram.rvalid held low -> within the same cycle every valid and ready output is 0; after release, a fresh imem read of 0x8 completes normally.
